// File: rtl/gcd_pkg.sv
`default_nettype none
//============================================================================
// Module   : gcd_pkg
// Brief    : Shared GCD definitions: bus width and initiator state encoding.
// Revision : 1.0
//============================================================================
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        GI_IDLE  = 3'd0,
        GI_A_REQ = 3'd1,
        GI_A_REL = 3'd2,
        GI_B_REQ = 3'd3,
        GI_B_REL = 3'd4,
        GI_RESP  = 3'd5,
        GI_HALT  = 3'd6
    } gcd_init_state_e;

endpackage
`default_nettype wire

// File: rtl/gcd_initiator_if.sv
`default_nettype none
//============================================================================
// Module   : gcd_initiator_if
// Brief    : Upstream pair, core req/ack and downstream result signals.
// Revision : 1.0
//============================================================================
interface gcd_initiator_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic             out_err;

    modport master (
        input  in_valid, in_a, in_b, ack, c, out_ready,
        output in_ready, req, ab, out_valid, out_c, out_err
    );

    modport slave (
        output in_valid, in_a, in_b, ack, c, out_ready,
        input  in_ready, req, ab, out_valid, out_c, out_err
    );
endinterface
`default_nettype wire

// File: rtl/gcd_watchdog.sv
`default_nettype none
//============================================================================
// Module   : gcd_watchdog
// Brief    : Clearable, enabled counter flagging TIMEOUT cycles of waiting.
// Revision : 1.0
//============================================================================
module gcd_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam int                 c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Saturates at the limit so a long stall never wraps back to a safe value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/gcd_initiator.sv
`default_nettype none
//============================================================================
// Module   : gcd_initiator
// Brief    : Drives the GCD core's four-phase req/ack with A then B, returns result.
// Revision : 1.0
//============================================================================
module gcd_initiator
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 4096
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    gcd_initiator_if.master bus
);
    gcd_init_state_e  r_state;
    gcd_init_state_e  w_next_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ab;
    logic [WIDTH-1:0] r_out_c;
    logic             r_req;
    logic             r_out_valid;
    logic             r_out_err;
    logic             w_accept;
    logic             w_zero_op;
    logic             w_wait;
    logic             w_state_change;
    logic             w_expired;

    assign w_accept       = (r_state == GI_IDLE) && bus.in_valid;
    assign w_zero_op      = (bus.in_a == '0) || (bus.in_b == '0);
    assign w_wait         = r_state inside {GI_A_REQ, GI_A_REL, GI_B_REQ, GI_B_REL};
    assign w_state_change = (w_next_state != r_state);

    gcd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_clear   (w_state_change),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    // The awaited ack level is tested first so it wins over a same-cycle timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            GI_IDLE:  if (w_accept) w_next_state = w_zero_op ? GI_RESP : GI_A_REQ;
            GI_A_REQ: if (bus.ack)        w_next_state = GI_A_REL;
                      else if (w_expired) w_next_state = GI_HALT;
            GI_A_REL: if (!bus.ack)       w_next_state = GI_B_REQ;
                      else if (w_expired) w_next_state = GI_HALT;
            GI_B_REQ: if (bus.ack)        w_next_state = GI_B_REL;
                      else if (w_expired) w_next_state = GI_HALT;
            GI_B_REL: if (!bus.ack)       w_next_state = GI_RESP;
                      else if (w_expired) w_next_state = GI_HALT;
            GI_RESP:  if (r_out_valid && bus.out_ready) w_next_state = GI_IDLE;
            GI_HALT:  w_next_state = GI_HALT;
            default:  w_next_state = GI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= GI_IDLE;
            r_b         <= '0;
            r_ab        <= '0;
            r_req       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                GI_IDLE: begin
                    if (w_accept) begin
                        if (w_zero_op) begin
                            r_out_c     <= '0;
                            r_out_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_ab  <= bus.in_a;
                            r_b   <= bus.in_b;
                            r_req <= 1'b1;
                        end
                    end
                end
                GI_A_REQ: begin
                    if (bus.ack) r_req <= 1'b0;
                end
                GI_A_REL: begin
                    if (!bus.ack) begin
                        r_ab  <= r_b;
                        r_req <= 1'b1;
                    end
                end
                GI_B_REQ: begin
                    if (bus.ack) begin
                        r_out_c   <= bus.c;
                        r_out_err <= 1'b0;
                        r_req     <= 1'b0;
                    end
                end
                GI_B_REL: begin
                    if (!bus.ack) r_out_valid <= 1'b1;
                end
                GI_RESP, GI_HALT: begin
                    if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
            // Core state is unknown after a timeout: report once, then stay parked.
            if ((w_next_state == GI_HALT) && (r_state != GI_HALT)) begin
                r_req       <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_c     <= '0;
                r_out_err   <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == GI_IDLE);
    assign bus.req       = r_req;
    assign bus.ab        = r_ab;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = r_out_c;
    assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_initiator.sv
`default_nettype none
//============================================================================
// Module   : tb_gcd_initiator
// Brief    : Bench for gcd_initiator with a behavioural GCD core and result model.
// Revision : 1.0
//============================================================================
module tb_gcd_initiator;
    import gcd_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        err;
    } txn_t;

    typedef struct packed {
        logic [15:0] c;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_to;
    int   checks    = 0;
    int   failures  = 0;
    bit   rnd_ready = 1'b0;
    txn_t q[$];
    res_t got[$];
    int   req_rises = 0;
    logic prev_req  = 1'b0;

    gcd_initiator_if bus ();
    gcd_initiator_if bus_to ();

    gcd_initiator dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    gcd_initiator #(
        .TIMEOUT (16)
    ) dut_to (
        .clk     (clk),
        .reset_n (rst_n_to),
        .bus     (bus_to)
    );

    always #5 clk = ~clk;

    assign bus_to.ack = 1'b0;
    assign bus_to.c   = '0;

    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural core: four-phase slave with random response delays.
    int          cs;
    int          dly;
    logic [15:0] core_a;
    logic [15:0] core_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= 0;
            dly     <= 0;
            bus.ack <= 1'b0;
            bus.c   <= '0;
            core_a  <= '0;
            core_b  <= '0;
        end else begin
            case (cs)
                0: if (bus.req) begin core_a <= bus.ab; dly <= int'($urandom_range(0, 3)); cs <= 1; end
                1: if (dly == 0) begin bus.ack <= 1'b1; cs <= 2; end else dly <= dly - 1;
                2: if (!bus.req) begin dly <= int'($urandom_range(0, 3)); cs <= 3; end
                3: if (dly == 0) begin bus.ack <= 1'b0; cs <= 4; end else dly <= dly - 1;
                4: if (bus.req) begin core_b <= bus.ab; dly <= int'($urandom_range(0, 6)); cs <= 5; end
                5: if (dly == 0) begin
                       bus.ack <= 1'b1;
                       bus.c   <= 16'(gcd_ref(int'(core_a), int'(core_b)));
                       cs      <= 6;
                   end else dly <= dly - 1;
                6: if (!bus.req) begin dly <= int'($urandom_range(0, 3)); cs <= 7; end
                7: if (dly == 0) begin
                       bus.ack <= 1'b0;
                       bus.c   <= 16'($urandom);
                       cs      <= 0;
                   end else dly <= dly - 1;
                default: cs <= 0;
            endcase
        end
    end

    // Reference model and per-cycle compare for the main instance.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                req_rises = 0;
                prev_req  = 1'b0;
            end else begin
                chk("in_ready", bus.in_ready, (q.size() == 0));
                if (bus.req) begin
                    if (!prev_req) req_rises++;
                    chk("req_allowed", (q.size() != 0) && !q[0].err, 1);
                    if (q.size() != 0)
                        chk("ab", bus.ab, (req_rises == 1) ? q[0].a : q[0].b);
                end
                prev_req = bus.req;
                if (bus.out_valid) begin
                    chk("out_expected", (q.size() != 0), 1);
                    if (q.size() != 0) begin
                        chk("out_c", bus.out_c, q[0].c);
                        chk("out_err", bus.out_err, q[0].err);
                        if (bus.out_ready) begin
                            chk("req_phases", req_rises, q[0].err ? 0 : 2);
                            got.push_back('{c: bus.out_c, err: bus.out_err});
                            void'(q.pop_front());
                            req_rises = 0;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (bus.in_a == 0 || bus.in_b == 0)
                        q.push_back('{a: bus.in_a, b: bus.in_b, c: 16'd0, err: 1'b1});
                    else
                        q.push_back('{a: bus.in_a, b: bus.in_b,
                                      c: 16'(gcd_ref(int'(bus.in_a), int'(bus.in_b))), err: 1'b0});
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 1000) begin
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("send_accept_bound", (n < 1000), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 2000) begin
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("drain_bound", (n < 2000), 1);
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        while (bus.req !== lvl && n < 200) begin
            tick();
            n++;
        end
        chk("wait_req_bound", (n < 200), 1);
    endtask

    task automatic check_got(input int idx, input logic [15:0] c, input logic err);
        if (idx >= got.size()) begin
            chk("got_count", got.size(), idx + 1);
        end else begin
            chk("got_c", got[idx].c, c);
            chk("got_err", got[idx].err, err);
        end
    endtask

    initial begin
        int          n;
        int          bad;
        int          g;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n            = 1'b0;
        rst_n_to         = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.out_ready    = 1'b1;
        bus_to.in_valid  = 1'b0;
        bus_to.in_a      = '0;
        bus_to.in_b      = '0;
        bus_to.out_ready = 1'b0;
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_req", bus.req, 0);
        chk("rst_ab", bus.ab, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_c", bus.out_c, 0);
        chk("rst_out_err", bus.out_err, 0);
        tick();
        rst_n    = 1'b1;
        rst_n_to = 1'b1;
        tick();

        // Single pair against the core
        send(16'd12, 16'd18);
        drain();
        chk("t1_count", got.size(), 1);
        check_got(0, 16'd6, 1'b0);

        // Back-to-back pairs
        send(16'd7, 16'd7);
        send(16'd1, 16'd65535);
        send(16'd48, 16'd36);
        drain();
        check_got(1, 16'd7, 1'b0);
        check_got(2, 16'd1, 1'b0);
        check_got(3, 16'd12, 1'b0);

        // Zero operands bypass the core
        send(16'd0, 16'd5);
        send(16'd9, 16'd0);
        send(16'd9, 16'd6);
        drain();
        check_got(4, 16'd0, 1'b1);
        check_got(5, 16'd0, 1'b1);
        check_got(6, 16'd3, 1'b0);

        // Backpressure holds the result
        bus.out_ready = 1'b0;
        send(16'd100, 16'd75);
        n = 0;
        while (!bus.out_valid && n < 200) begin tick(); n++; end
        chk("bp_valid_bound", (n < 200), 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_c !== 16'd25 || bus.out_err !== 1'b0) bad++;
            tick();
        end
        chk("bp_hold_bad_cycles", bad, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_consumed", bus.out_valid, 0);
        drain();
        check_got(7, 16'd25, 1'b0);

        // Reset during the B request phase
        send(16'd21, 16'd14);
        wait_req(1'b1);
        wait_req(1'b0);
        wait_req(1'b1);
        chk("mid_pre_req", bus.req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_req_async", bus.req, 0);
        chk("mid_out_valid_async", bus.out_valid, 0);
        chk("mid_in_ready_async", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_got_unchanged", got.size(), 8);
        send(16'd21, 16'd14);
        drain();
        check_got(8, 16'd7, 1'b0);

        // Randomized pairs with random downstream readiness
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            g  = int'($urandom_range(1, 60));
            ra = 16'(g * int'($urandom_range(0, 30)));
            rb = 16'(g * int'($urandom_range(0, 30)));
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
            send(ra, rb);
            repeat ($urandom_range(0, 2)) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        drain();
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        chk("total_outputs", got.size(), 49);

        // Timeout instance: ack never rises
        chk("to_in_ready_idle", bus_to.in_ready, 1);
        bus_to.in_a     = 16'd3;
        bus_to.in_b     = 16'd5;
        bus_to.in_valid = 1'b1;
        tick();
        bus_to.in_valid = 1'b0;
        n = 0;
        while (bus_to.req && n < 100) begin n++; tick(); end
        chk("to_req_cycles", n, 16);
        chk("to_req_low", bus_to.req, 0);
        chk("to_out_valid", bus_to.out_valid, 1);
        chk("to_out_err", bus_to.out_err, 1);
        chk("to_out_c", bus_to.out_c, 0);
        repeat (3) tick();
        chk("to_out_held", bus_to.out_valid, 1);
        bus_to.out_ready = 1'b1;
        tick();
        bus_to.out_ready = 1'b0;
        chk("to_consumed", bus_to.out_valid, 0);
        bus_to.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_to.in_ready !== 1'b0 || bus_to.req !== 1'b0 || bus_to.out_valid !== 1'b0) bad++;
            tick();
        end
        chk("to_dead_bad_cycles", bad, 0);
        bus_to.in_valid = 1'b0;
        rst_n_to = 1'b0;
        #1;
        chk("to_reset_in_ready", bus_to.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n_to = 1'b1;
        tick();
        chk("to_recovered_in_ready", bus_to.in_ready, 1);
        chk("to_recovered_out_valid", bus_to.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
